// File: rtl/dsi_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsi_tx_pkg
//  Description : Shared constants and helpers for the DSI TX line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsi_tx_pkg;

   // Ceiling log2 for sizing address buses (value >= 1)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // err_status bit positions
   localparam int ERR_UNDERFLOW = 0;
   localparam int ERR_OVERFLOW  = 1;
   localparam int ERR_SOP       = 2;
   localparam int ERR_W         = 3;

   // LINE_MODE encodings
   localparam int LINE_MODE_THRESHOLD = 0;
   localparam int LINE_MODE_COMPLETE  = 1;

endpackage
`default_nettype wire

// File: rtl/dsi_sc_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dsi_sc_ram
//  Description : Simple dual-port RAM, synchronous write, asynchronous read.
//                Written in the plain style every vendor infers as RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsi_sc_ram
   import dsi_tx_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 1024
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [clog2(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [clog2(DEPTH)-1:0]   rd_addr,
   output logic [WIDTH-1:0]          rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage write port; contents are not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/dsi_tx_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dsi_tx_line_buffer
//  Description : Single-clock show-ahead pixel line buffer between an
//                Avalon-ST pixel source and the DSI packet assembler. Stores
//                EOP with each word, counts complete lines, reports line
//                readiness, supports flush and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsi_tx_line_buffer
   import dsi_tx_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 1024,
   parameter int AFULL_MARGIN = 64,
   parameter int LINE_MODE    = 0,
   parameter int LCNT_W       = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_WIDTH-1:0]     avl_st_in_data,
   input  logic                      avl_st_in_valid,
   input  logic                      avl_st_in_startofpacket,
   input  logic                      avl_st_in_endofpacket,
   output logic                      avl_st_in_ready,
   input  logic [clog2(DEPTH):0]     line_threshold,
   input  logic                      flush,
   output logic [DATA_WIDTH-1:0]     fifo_data,
   output logic                      fifo_eop,
   output logic                      fifo_not_empty,
   output logic                      fifo_line_ready,
   input  logic                      fifo_read_ack,
   output logic [clog2(DEPTH):0]     fifo_usedw,
   output logic [LCNT_W-1:0]         lines_stored,
   output logic [ERR_W-1:0]          err_status,
   input  logic                      err_clear
);

   localparam int              AW          = clog2(DEPTH);
   localparam logic [AW:0]     FULL_LEVEL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]     READY_LIMIT = (AW+1)'(DEPTH - AFULL_MARGIN);
   localparam logic [LCNT_W-1:0] LCNT_MAX  = '1;

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         usedw;
   logic [LCNT_W-1:0]   lcnt;
   logic                ready;
   logic                line_ready;
   logic [ERR_W-1:0]    err;
   logic                open_pkt;

   logic                full;
   logic                not_empty;
   logic                wr;
   logic                rd;
   logic                wr_eop;
   logic                rd_eop;
   logic                head_eop;
   logic [AW:0]         usedw_next;
   logic [LCNT_W-1:0]   lcnt_next;
   logic [ERR_W-1:0]    err_set;
   logic [ERR_W-1:0]    err_next;
   logic                open_next;
   logic                ready_next;
   logic                line_ready_next;
   logic [DATA_WIDTH:0] head_word;

   // Storage holds {eop, data}; head word is read combinationally
   dsi_sc_ram #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr),
      .wr_addr (wr_ptr),
      .wr_data ({avl_st_in_endofpacket, avl_st_in_data}),
      .rd_addr (rd_ptr),
      .rd_data (head_word)
   );

   assign head_eop = head_word[DATA_WIDTH];

   // Transfer qualification, next-state occupancy, line count and errors
   always_comb begin
      full      = (usedw == FULL_LEVEL);
      not_empty = (usedw != '0);
      wr        = avl_st_in_valid & ready & !full & !flush;
      rd        = fifo_read_ack & not_empty & !flush;
      wr_eop    = wr & avl_st_in_endofpacket;
      rd_eop    = rd & head_eop;

      usedw_next = usedw;
      if (flush) begin
         usedw_next = '0;
      end else if (wr && !rd) begin
         usedw_next = usedw + 1'b1;
      end else if (rd && !wr) begin
         usedw_next = usedw - 1'b1;
      end

      // Saturating line counter; decrement guarded so it never wraps below 0
      lcnt_next = lcnt;
      if (flush) begin
         lcnt_next = '0;
      end else if (wr_eop && !rd_eop) begin
         if (lcnt != LCNT_MAX) begin
            lcnt_next = lcnt + 1'b1;
         end
      end else if (rd_eop && !wr_eop) begin
         if (lcnt != '0) begin
            lcnt_next = lcnt - 1'b1;
         end
      end

      err_set                = '0;
      err_set[ERR_UNDERFLOW] = fifo_read_ack & !not_empty;
      err_set[ERR_OVERFLOW]  = avl_st_in_valid & ready & full;
      err_set[ERR_SOP]       = wr & avl_st_in_startofpacket & open_pkt;
      // A newly raised error survives a simultaneous clear
      err_next = (err_clear ? '0 : err) | err_set;

      open_next = open_pkt;
      if (flush) begin
         open_next = 1'b0;
      end else if (wr) begin
         open_next = !avl_st_in_endofpacket;
      end

      // Ready lags fill by one cycle; the margin absorbs the in-flight word
      ready_next = (usedw_next < READY_LIMIT) & !flush;
   end

   generate
      if (LINE_MODE == LINE_MODE_COMPLETE) begin : g_line_complete
         assign line_ready_next = (lcnt_next != '0);
      end else begin : g_line_threshold
         logic [AW:0] thr_eff;
         // A zero threshold would make an empty buffer "ready"; clamp to 1
         assign thr_eff         = (line_threshold == '0) ? {{AW{1'b0}}, 1'b1} : line_threshold;
         assign line_ready_next = (usedw_next >= thr_eff);
      end
   endgenerate

   // State registers: pointers, occupancy, flags and sticky errors
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         usedw      <= '0;
         lcnt       <= '0;
         ready      <= 1'b0;
         line_ready <= 1'b0;
         err        <= '0;
         open_pkt   <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
         usedw      <= usedw_next;
         lcnt       <= lcnt_next;
         ready      <= ready_next;
         line_ready <= line_ready_next;
         err        <= err_next;
         open_pkt   <= open_next;
      end
   end

   assign avl_st_in_ready = ready;
   assign fifo_data       = head_word[DATA_WIDTH-1:0];
   assign fifo_eop        = head_eop;
   assign fifo_not_empty  = not_empty;
   assign fifo_line_ready = line_ready;
   assign fifo_usedw      = usedw;
   assign lines_stored    = lcnt;
   assign err_status      = err;

endmodule
`default_nettype wire

// File: tb/tb_dsi_tx_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsi_tx_line_buffer
//  Description : Self-checking bench for dsi_tx_line_buffer. Two instances
//                share stimulus: one in complete-line mode, one in
//                threshold mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsi_tx_line_buffer;

   logic        clk;
   logic        rst_n;
   logic [31:0] data;
   logic        valid;
   logic        sop;
   logic        eop;
   logic [10:0] line_threshold;
   logic        flush;
   logic        ack;
   logic        eclr;

   logic        ready,   m0_ready;
   logic [31:0] head,    m0_head;
   logic        heop,    m0_heop;
   logic        ne,      m0_ne;
   logic        lr,      m0_lr;
   logic [10:0] usedw,   m0_usedw;
   logic [7:0]  lines,   m0_lines;
   logic [2:0]  err,     m0_err;

   int checks = 0;
   int passes = 0;

   dsi_tx_line_buffer #(
      .DATA_WIDTH(32), .DEPTH(1024), .AFULL_MARGIN(64), .LINE_MODE(1), .LCNT_W(8)
   ) dut_m1 (
      .clk(clk), .rst_n(rst_n), .avl_st_in_data(data), .avl_st_in_valid(valid),
      .avl_st_in_startofpacket(sop), .avl_st_in_endofpacket(eop),
      .avl_st_in_ready(ready), .line_threshold(line_threshold), .flush(flush),
      .fifo_data(head), .fifo_eop(heop), .fifo_not_empty(ne), .fifo_line_ready(lr),
      .fifo_read_ack(ack), .fifo_usedw(usedw), .lines_stored(lines),
      .err_status(err), .err_clear(eclr)
   );

   dsi_tx_line_buffer #(
      .DATA_WIDTH(32), .DEPTH(1024), .AFULL_MARGIN(64), .LINE_MODE(0), .LCNT_W(8)
   ) dut_m0 (
      .clk(clk), .rst_n(rst_n), .avl_st_in_data(data), .avl_st_in_valid(valid),
      .avl_st_in_startofpacket(sop), .avl_st_in_endofpacket(eop),
      .avl_st_in_ready(m0_ready), .line_threshold(line_threshold), .flush(flush),
      .fifo_data(m0_head), .fifo_eop(m0_heop), .fifo_not_empty(m0_ne),
      .fifo_line_ready(m0_lr), .fifo_read_ack(ack), .fifo_usedw(m0_usedw),
      .lines_stored(m0_lines), .err_status(m0_err), .err_clear(eclr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid, sop, eop;
      logic [31:0] data;
      logic        ack, flush, eclr;
      logic [10:0] e_usedw;
      logic        e_ne;
      logic [7:0]  e_lines;
      logic        e_lr;
      logic [2:0]  e_err;
      logic        e_rdy;
      logic [31:0] e_head;
      logic        e_heop;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic idle_inputs();
      valid = 1'b0; sop = 1'b0; eop = 1'b0; ack = 1'b0; flush = 1'b0; eclr = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Flush, then one idle cycle so ready is back up
   task automatic flush_cycle();
      idle_inputs();
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
   endtask

   task automatic write_word(input logic [31:0] d, input logic s, input logic e);
      valid = 1'b1; data = d; sop = s; eop = e;
      step();
      valid = 1'b0; sop = 1'b0; eop = 1'b0;
   endtask

   initial begin
      int  acc;
      bit  done;
      bit  rdy;

      // Complete-line read sequence followed by error-flag sequence
      //          v  s  e  data          ak fl ec  usedw  ne lines lr err    rdy head          heop
      vecs[0]  = '{0, 0, 0, 32'h0,        0, 0, 0, 11'd0, 0, 8'd0, 0, 3'b000, 1, 32'h0,        0};
      vecs[1]  = '{1, 1, 0, 32'hA000_0000, 0, 0, 0, 11'd1, 1, 8'd0, 0, 3'b000, 1, 32'hA000_0000, 0};
      vecs[2]  = '{1, 0, 0, 32'hA000_0001, 0, 0, 0, 11'd2, 1, 8'd0, 0, 3'b000, 1, 32'hA000_0000, 0};
      vecs[3]  = '{1, 0, 0, 32'hA000_0002, 0, 0, 0, 11'd3, 1, 8'd0, 0, 3'b000, 1, 32'hA000_0000, 0};
      vecs[4]  = '{1, 0, 1, 32'hA000_0003, 0, 0, 0, 11'd4, 1, 8'd1, 1, 3'b000, 1, 32'hA000_0000, 0};
      vecs[5]  = '{0, 0, 0, 32'h0,        1, 0, 0, 11'd3, 1, 8'd1, 1, 3'b000, 1, 32'hA000_0001, 0};
      vecs[6]  = '{0, 0, 0, 32'h0,        1, 0, 0, 11'd2, 1, 8'd1, 1, 3'b000, 1, 32'hA000_0002, 0};
      vecs[7]  = '{0, 0, 0, 32'h0,        1, 0, 0, 11'd1, 1, 8'd1, 1, 3'b000, 1, 32'hA000_0003, 1};
      vecs[8]  = '{0, 0, 0, 32'h0,        1, 0, 0, 11'd0, 0, 8'd0, 0, 3'b000, 1, 32'h0,        0};
      vecs[9]  = '{0, 0, 0, 32'h0,        1, 0, 0, 11'd0, 0, 8'd0, 0, 3'b001, 1, 32'h0,        0};
      vecs[10] = '{1, 1, 0, 32'hB000_0000, 0, 0, 0, 11'd1, 1, 8'd0, 0, 3'b001, 1, 32'hB000_0000, 0};
      vecs[11] = '{1, 1, 0, 32'hB000_0001, 0, 0, 0, 11'd2, 1, 8'd0, 0, 3'b101, 1, 32'hB000_0000, 0};
      vecs[12] = '{0, 0, 0, 32'h0,        0, 0, 1, 11'd2, 1, 8'd0, 0, 3'b000, 1, 32'hB000_0000, 0};
      vecs[13] = '{1, 1, 1, 32'hB000_0002, 0, 0, 1, 11'd3, 1, 8'd1, 1, 3'b100, 1, 32'hB000_0000, 0};
      vecs[14] = '{0, 0, 0, 32'h0,        0, 0, 1, 11'd3, 1, 8'd1, 1, 3'b000, 1, 32'hB000_0000, 0};

      idle_inputs();
      data           = '0;
      line_threshold = 11'd160;
      rst_n          = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", {usedw, ne, lines, lr, m0_lr, err, ready},
            {11'd0, 1'b0, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0});
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         valid = vecs[i].valid; sop = vecs[i].sop; eop = vecs[i].eop; data = vecs[i].data;
         ack = vecs[i].ack; flush = vecs[i].flush; eclr = vecs[i].eclr;
         step();
         check($sformatf("vec%0d_status", i), {usedw, ne, lines, lr, err, ready},
               {vecs[i].e_usedw, vecs[i].e_ne, vecs[i].e_lines, vecs[i].e_lr,
                vecs[i].e_err, vecs[i].e_rdy});
         if (vecs[i].e_ne)
            check($sformatf("vec%0d_head", i), {heop, head}, {vecs[i].e_heop, vecs[i].e_head});
      end
      idle_inputs();

      // Threshold mode: ready-line flag tracks fill against threshold
      flush_cycle();
      line_threshold = 11'd160;
      for (int i = 0; i < 159; i++) write_word(32'h2000_0000 + 32'(i), (i == 0), 1'b0);
      check("thr_159_words", {m0_usedw, m0_lr}, {11'd159, 1'b0});
      write_word(32'h2000_0000 + 32'd159, 1'b0, 1'b0);
      check("thr_160_words", {m0_usedw, m0_lr}, {11'd160, 1'b1});
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("thr_after_read", {m0_usedw, m0_lr}, {11'd159, 1'b0});

      flush_cycle();
      line_threshold = 11'd0;
      check("thr0_empty", {m0_usedw, m0_lr}, {11'd0, 1'b0});
      write_word(32'h2100_0000, 1'b1, 1'b0);
      check("thr0_one_word", {m0_usedw, m0_lr}, {11'd1, 1'b1});
      line_threshold = 11'd160;

      // Continuous writes with no reads until back-pressure
      flush_cycle();
      acc  = 0;
      done = 1'b0;
      valid = 1'b1;
      for (int c = 0; c < 2000 && !done; c++) begin
         rdy  = ready;
         data = 32'h3000_0000 + 32'(acc);
         step();
         if (rdy) acc++;
         if (!ready) done = 1'b1;
      end
      valid = 1'b0;
      check("fill_ready_dropped", 64'(done), 64'd1);
      check("fill_usedw_at_drop", 64'(usedw), 64'd960);
      check("fill_no_word_lost", 64'(usedw), 64'(acc));
      check("fill_err_clean", 64'(err), 64'd0);
      for (int k = 0; k < 960; k++) begin
         check("fill_readback", 64'(head), 64'(32'h3000_0000 + 32'(k)));
         ack = 1'b1;
         step();
      end
      ack = 1'b0;
      check("fill_drained", {usedw, ne}, {11'd0, 1'b0});

      // Simultaneous read and write at a fill of one across pointer wrap
      flush_cycle();
      write_word(32'h4000_0000, 1'b1, 1'b0);
      for (int n = 1; n <= 2000; n++) begin
         check("rw_fill1", {usedw, head}, {11'd1, 32'h4000_0000 + 32'(n - 1)});
         valid = 1'b1; data = 32'h4000_0000 + 32'(n); ack = 1'b1;
         step();
      end
      idle_inputs();
      check("rw_final", {usedw, head, err}, {11'd1, 32'h4000_0000 + 32'd2000, 3'b000});

      // Flush with concurrent write and read; error flags survive the flush
      flush_cycle();
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("underflow_flag", 64'(err), 64'b001);
      for (int i = 0; i < 300; i++)
         write_word(32'h6000_0000 + 32'(i), (i % 100 == 0), (i % 100 == 99));
      check("pre_flush_fill", {usedw, lines}, {11'd300, 8'd3});
      valid = 1'b1; data = 32'h6FFF_FFFF; ack = 1'b1; flush = 1'b1;
      step();
      idle_inputs();
      check("flush_result", {usedw, lines, ne, ready, lr, err},
            {11'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b001});
      step();
      check("flush_ready_back", 64'(ready), 64'd1);

      // Reset mid-line: contents, open packet and errors all cleared
      write_word(32'h7000_0000, 1'b1, 1'b0);
      write_word(32'h7000_0001, 1'b0, 1'b0);
      rst_n = 1'b0;
      step();
      check("reset_midline", {usedw, ne, lines, err, ready}, {11'd0, 1'b0, 8'd0, 3'b000, 1'b0});
      rst_n = 1'b1;
      step();
      write_word(32'h7100_0000, 1'b1, 1'b0);
      check("reset_clears_open", {usedw, err, head}, {11'd1, 3'b000, 32'h7100_0000});

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
